// File: rtl/orion_pkg.sv
// Shared constants, arbiter state encoding and round-robin helper for the sequence RAM arbiter.
package orion_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 4;
  localparam int NUM_REQ    = 3;
  localparam int PTR_W      = 2;

  localparam int REQ_SEQ = 0;
  localparam int REQ_GC  = 1;
  localparam int REQ_REC = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } arb_state_e;

  // Pointer value that follows a one-hot winner: (W+1) mod NUM_REQ.
  function automatic logic [PTR_W-1:0] rrNext(input logic [NUM_REQ-1:0] oh);
    rrNext = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (oh[i]) rrNext = PTR_W'((i + 1) % NUM_REQ);
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// Picks the first requester at or after ptr (wrapping); ptr tied to 0 gives fixed priority.
module rr_priority_picker
  import orion_pkg::*;
#(
  parameter int N = NUM_REQ
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner
);
  logic [PTR_W-1:0] idx;

  // Walk the search order backwards so the highest-priority hit is written last.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ram_access_arbiter.sv
// Three-way sequence RAM arbiter with burst lock. Define ORION_RAM_ARB_RR_EN for
// round-robin arbitration; otherwise fixed priority (bit0 highest).
module ram_access_arbiter
  import orion_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_q,
  output logic                      busy
);
  logic [NUM_REQ-1:0][ADDR_W-1:0] addrV;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdataV;
  arb_state_e                     state, nxt;
  logic [NUM_REQ-1:0]             own, pick, sel;
  logic [PTR_W-1:0]               ptr;
  logic                           launch, selWe, rdPend;
  logic [ADDR_W-1:0]              selAddr;
  logic [DATA_W-1:0]              selWd;
  logic [NUM_REQ-1:0]             rdOwn;

  assign addrV  = addr_in;
  assign wdataV = wdata_in;

  rr_priority_picker #(.N(NUM_REQ)) uPick (.req(req), .ptr(ptr), .winner(pick));

`ifdef ORION_RAM_ARB_RR_EN
  logic [PTR_W-1:0] rrPtr;
  always_ff @(posedge clk) begin
    if (!rst)                                rrPtr <= '0;
    else if (state == ST_IDLE && launch)     rrPtr <= rrNext(pick);
  end
  assign ptr = rrPtr;
`else
  assign ptr = '0;
`endif

  // Non-owner lock bits never reach the FSM: only own-masked req/lock are used.
  always_comb begin
    nxt    = state;
    launch = 1'b0;
    sel    = '0;
    case (state)
      ST_IDLE: if (|req) begin
        launch = 1'b1;
        sel    = pick;
        nxt    = ST_ACCESS;
      end
      ST_ACCESS: nxt = (|(lock & own)) ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (|(req & own)) begin
          launch = 1'b1;
          sel    = own;
          nxt    = ST_ACCESS;
        end else if (!(|(lock & own))) begin
          nxt = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    selAddr = '0;
    selWd   = '0;
    selWe   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel[i]) begin
        selAddr = addrV[i];
        selWd   = wdataV[i];
        selWe   = we[i];
      end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      own       <= '0;
      gnt       <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      rdPend    <= 1'b0;
      rdOwn     <= '0;
      rvalid    <= '0;
      rdata     <= '0;
    end else begin
      state     <= nxt;
      gnt       <= launch ? sel : '0;
      ram_addr  <= launch ? selAddr : '0;
      ram_we    <= launch & selWe;
      ram_wdata <= (launch & selWe) ? selWd : '0;
      if (launch) own <= sel;
      // Reads retire two cycles after ACCESS; the FSM never waits on them.
      rdPend    <= (state == ST_ACCESS) & ~ram_we;
      rdOwn     <= gnt;
      rvalid    <= rdPend ? rdOwn : '0;
      if (rdPend) rdata <= ram_q;
    end
  end

  assign busy = (state != ST_IDLE) | rdPend;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: directed table, corner sequences, random traffic vs model.
module tb_ram_access_arbiter;
  localparam int AW = 5;
  localparam int DW = 4;
`ifdef ORION_RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req, we, lock;
  logic [3*AW-1:0] addrIn;
  logic [3*DW-1:0] wdataIn;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata, ramWdata, ramQ;
  logic [AW-1:0] ramAddr;
  logic          ramWe, busy;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] refMem [32];
  logic          memClr = 1'b0;

  int vecs = 0;
  int errs = 0;

  ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr_in(addrIn), .wdata_in(wdataIn), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .ram_addr(ramAddr), .ram_wdata(ramWdata), .ram_we(ramWe),
    .ram_q(ramQ), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memClr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      ramQ <= mem[ramAddr];
    end
  end

  typedef struct {
    int         id;
    logic       w;
    logic [4:0] a;
    logic [3:0] d;
    logic [2:0] expGnt;
    logic [3:0] expRd;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic doReset();
    req = '0; we = '0; lock = '0; addrIn = '0; wdataIn = '0;
    rst = 1'b0; memClr = 1'b1;
    for (int i = 0; i < 32; i++) refMem[i] = '0;
    tick(); tick();
    rst = 1'b1; memClr = 1'b0;
  endtask

  task automatic setReq(input int id, input logic w, input logic [4:0] a, input logic [3:0] d);
    req[id] = 1'b1;
    we[id]  = w;
    addrIn[id*AW +: AW]  = a;
    wdataIn[id*DW +: DW] = d;
  endtask

  // Reference arbitration: first requester found scanning from ptr upward, wrapping.
  function automatic logic [2:0] pickRef(input logic [2:0] r, input int p);
    for (int k = 0; k < 3; k++)
      if (r[(p + k) % 3]) return 3'(1 << ((p + k) % 3));
    return 3'b000;
  endfunction

  function automatic int ohIdx(input logic [2:0] oh);
    for (int i = 0; i < 3; i++) if (oh[i]) return i;
    return 0;
  endfunction

  initial begin
    vec_t tbl[7];
    logic [2:0] simExp[3];
    logic [2:0] simGot[3];
    int n, cnt, last, cyc;
    bit got1, seen;

    tbl[0] = '{0, 1'b1, 5'd5,  4'd9, 3'b001, 4'd0};
    tbl[1] = '{1, 1'b0, 5'd5,  4'd0, 3'b010, 4'd9};
    tbl[2] = '{2, 1'b1, 5'd31, 4'hF, 3'b100, 4'd0};
    tbl[3] = '{2, 1'b0, 5'd31, 4'd0, 3'b100, 4'hF};
    tbl[4] = '{1, 1'b1, 5'd0,  4'd3, 3'b010, 4'd0};
    tbl[5] = '{0, 1'b0, 5'd0,  4'd0, 3'b001, 4'd3};
    tbl[6] = '{0, 1'b0, 5'd5,  4'd0, 3'b001, 4'd9};

    // Reset state
    doReset();
    check("rst gnt", 32'(gnt), 0);
    check("rst rvalid", 32'(rvalid), 0);
    check("rst rdata", 32'(rdata), 0);
    check("rst ram_addr", 32'(ramAddr), 0);
    check("rst ram_wdata", 32'(ramWdata), 0);
    check("rst ram_we", 32'(ramWe), 0);
    check("rst busy", 32'(busy), 0);

    // Directed single accesses
    for (int v = 0; v < 7; v++) begin
      setReq(tbl[v].id, tbl[v].w, tbl[v].a, tbl[v].d);
      tick();
      check("tbl gnt", 32'(gnt), 32'(tbl[v].expGnt));
      check("tbl ram_addr", 32'(ramAddr), 32'(tbl[v].a));
      check("tbl ram_we", 32'(ramWe), 32'(tbl[v].w));
      check("tbl ram_wdata", 32'(ramWdata), tbl[v].w ? 32'(tbl[v].d) : 0);
      req = '0; we = '0;
      tick(); tick();
      check("tbl rvalid", 32'(rvalid), tbl[v].w ? 0 : 32'(tbl[v].expGnt));
      if (!tbl[v].w) check("tbl rdata", 32'(rdata), 32'(tbl[v].expRd));
    end

    // Simultaneous requests held for three grants
    doReset();
    simExp[0] = 3'b001;
    simExp[1] = RR ? 3'b010 : 3'b001;
    simExp[2] = RR ? 3'b100 : 3'b001;
    req = 3'b111;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      tick();
      if (gnt != 0) begin simGot[n] = gnt; n++; end
    end
    req = '0;
    check("sim grant count", 32'(n), 3);
    for (int i = 0; i < n; i++) check("sim order", 32'(simGot[i]), 32'(simExp[i]));
    tick(); tick(); tick();

    // Locked burst of 16 writes with a competing requester
    doReset();
    lock = 3'b001;
    setReq(0, 1'b1, 5'd0, 4'd0);
    setReq(1, 1'b0, 5'd7, 4'd0);
    cnt = 0; last = 0; got1 = 0;
    for (cyc = 0; cyc < 120 && !got1; cyc++) begin
      tick();
      if (gnt[0]) begin
        if (cnt > 0) check("burst gap", 32'(cyc - last), 2);
        last = cyc;
        cnt++;
        if (cnt == 16) begin req[0] = 1'b0; lock[0] = 1'b0; end
        else setReq(0, 1'b1, 5'(cnt), 4'(cnt));
      end
      if (gnt[1]) begin
        check("gnt1 after burst", 32'(cnt), 16);
        req[1] = 1'b0;
        got1 = 1'b1;
      end
    end
    check("burst count", 32'(cnt), 16);
    check("burst gnt1 seen", 32'(got1), 1);
    tick(); tick(); tick();

    // Reset in the cycle before read data would return
    doReset();
    setReq(1, 1'b0, 5'd5, 4'd0);
    tick();
    check("midrd gnt", 32'(gnt), 32'b010);
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    check("midrd rvalid", 32'(rvalid), 0);
    check("midrd busy", 32'(busy), 0);
    check("midrd outs", 32'({gnt, rdata, ramAddr, ramWdata, ramWe}), 0);
    rst = 1'b1;

    // Request pulsed only during ACCESS must never be granted
    doReset();
    setReq(0, 1'b0, 5'd2, 4'd0);
    tick();
    check("drop first gnt", 32'(gnt), 32'b001);
    req = 3'b100;
    addrIn[2*AW +: AW] = 5'd9;
    tick();
    req = '0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gnt[2]) seen = 1;
    end
    check("drop no gnt2", 32'(seen), 0);

    // Random traffic against an abstract model (no lock)
    doReset();
    begin
      bit         pend[3];
      logic [4:0] tA[3];
      logic       tW[3];
      logic [3:0] tD[3];
      logic [2:0] prevReq, expG;
      bit         prevFree, p1v, p2v;
      int         ptrM, w, p1id, p2id;
      logic [3:0] p1d, p2d;
      for (int i = 0; i < 3; i++) pend[i] = 0;
      prevReq = '0; prevFree = 1; ptrM = 0;
      p1v = 0; p2v = 0; p1id = 0; p2id = 0; p1d = '0; p2d = '0;
      for (int c = 0; c < 400; c++) begin
        bit nv; int nid; logic [3:0] nd;
        tick();
        nv = 0; nid = 0; nd = '0;
        expG = prevFree ? pickRef(prevReq, RR ? ptrM : 0) : 3'b000;
        check("rand gnt", 32'(gnt), 32'(expG));
        if (expG != 0) begin
          w = ohIdx(expG);
          if (RR) ptrM = (w + 1) % 3;
          check("rand ram_addr", 32'(ramAddr), 32'(tA[w]));
          check("rand ram_we", 32'(ramWe), 32'(tW[w]));
          check("rand ram_wdata", 32'(ramWdata), tW[w] ? 32'(tD[w]) : 0);
          if (tW[w]) refMem[tA[w]] = tD[w];
          else begin nv = 1; nid = w; nd = refMem[tA[w]]; end
          pend[w] = 0;
        end else begin
          check("rand idle ram_we", 32'(ramWe), 0);
        end
        check("rand rvalid", 32'(rvalid), p2v ? 32'(1 << p2id) : 0);
        if (p2v) check("rand rdata", 32'(rdata), 32'(p2d));
        p2v = p1v; p2id = p1id; p2d = p1d;
        p1v = nv;  p1id = nid;  p1d = nd;
        prevFree = (expG == 0);
        for (int i = 0; i < 3; i++) begin
          if (!pend[i] && $urandom_range(0, 3) == 0) begin
            pend[i] = 1;
            tA[i] = 5'($urandom_range(0, 31));
            tW[i] = 1'($urandom_range(0, 1));
            tD[i] = 4'($urandom_range(0, 15));
          end
          req[i] = pend[i];
          if (pend[i]) setReq(i, tW[i], tA[i], tD[i]);
        end
        prevReq = req;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
